// File: rtl/mips_pkg.sv
// Shared opcode, FSM-state and shadow-slot definitions for the MIPS pipeline control.
package mips_pkg;

    localparam int OP_BITS  = 6;
    localparam int REG_BITS = 5;

    localparam logic [OP_BITS-1:0] OP_NO_OP = 6'b000000;
    localparam logic [OP_BITS-1:0] OP_ADD   = 6'b100001;
    localparam logic [OP_BITS-1:0] OP_SUB   = 6'b100010;
    localparam logic [OP_BITS-1:0] OP_AND   = 6'b100100;
    localparam logic [OP_BITS-1:0] OP_OR    = 6'b101000;
    localparam logic [OP_BITS-1:0] OP_SLT   = 6'b110000;
    localparam logic [OP_BITS-1:0] OP_MUL   = 6'b100000;
    localparam logic [OP_BITS-1:0] OP_HLT   = 6'b111111;
    localparam logic [OP_BITS-1:0] OP_LW    = 6'b000011;
    localparam logic [OP_BITS-1:0] OP_SW    = 6'b000110;
    localparam logic [OP_BITS-1:0] OP_ADDI  = 6'b001110;
    localparam logic [OP_BITS-1:0] OP_SUBI  = 6'b001101;
    localparam logic [OP_BITS-1:0] OP_SLTI  = 6'b010000;
    localparam logic [OP_BITS-1:0] OP_BNEQZ = 6'b000111;
    localparam logic [OP_BITS-1:0] OP_BEQZ  = 6'b011110;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    typedef struct packed {
        logic                valid;
        logic                writes;
        logic [REG_BITS-1:0] rd;
        logic                is_hlt;
    } slot_t;

    localparam int    SLOT_W    = $bits(slot_t);
    localparam slot_t SLOT_NONE = '0;

    typedef struct packed {
        logic reads_rs;
        logic reads_rt;
        logic writes_rd;
        logic is_hlt;
    } opclass_t;

endpackage

// File: rtl/mips_opclass.sv
// Opcode decoder: which register fields an instruction reads/writes, and HLT detect.
module mips_opclass
    import mips_pkg::*;
(
    input  logic [OP_BITS-1:0] op,
    output opclass_t           cls
);

    always_comb begin
        cls = '0;
        unique case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
                cls.reads_rs  = 1'b1;
                cls.reads_rt  = 1'b1;
                cls.writes_rd = 1'b1;
            end
            OP_SW: begin
                cls.reads_rs = 1'b1;
                cls.reads_rt = 1'b1;
            end
            OP_LW, OP_ADDI, OP_SUBI, OP_SLTI: begin
                cls.reads_rs  = 1'b1;
                cls.writes_rd = 1'b1;
            end
            OP_BEQZ, OP_BNEQZ: cls.reads_rs = 1'b1;
            OP_HLT:            cls.is_hlt   = 1'b1;
            default:           cls = '0;
        endcase
    end

endmodule

// File: rtl/mips_pipe_ctrl.sv
// Pipeline interlock controller: shadow EX/MEM/WB tags, RAW stall, branch flush,
// HLT drain/halt sequencing and bring-up counters.
module mips_pipe_ctrl
    import mips_pkg::*;
#(
    parameter int OPW   = 6,
    parameter int RW    = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic             mem_branch_taken,
    output logic             fetch_en,
    output logic             id_stall,
    output logic             id_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] retired
);

    state_t   state;
    slot_t    s2, s3, s4;
    opclass_t cls;

    logic [RW-1:0] rd, rs, rt;
    logic          active, flush, hazard, issue;
    slot_t         id_tag;
    logic          unused_bits;

    assign rd = id_instr[25 -: RW];
    assign rs = id_instr[25-RW -: RW];
    assign rt = id_instr[25-2*RW -: RW];
    assign unused_bits = ^id_instr[25-3*RW:0];

    mips_opclass u_opclass (
        .op  (id_instr[31 -: OPW]),
        .cls (cls)
    );

    function automatic logic hits(input slot_t s, input logic [RW-1:0] r);
        return s.valid && s.writes && (s.rd == r);
    endfunction

    // WB is checked too: the register file writes on the same edge ID reads it.
    always_comb begin
        hazard = id_valid &&
                 ((cls.reads_rs && (hits(s2, rs) || hits(s3, rs) || hits(s4, rs))) ||
                  (cls.reads_rt && (hits(s2, rt) || hits(s3, rt) || hits(s4, rt))));
        active = (state != ST_HALTED);
        flush  = active && mem_branch_taken;
        issue  = active && !flush && !hazard && id_valid && (state == ST_RUN);

        id_flush = flush;
        id_stall = active && !flush && hazard;

        id_tag        = SLOT_NONE;
        id_tag.valid  = 1'b1;
        id_tag.writes = cls.writes_rd;
        id_tag.rd     = rd;
        id_tag.is_hlt = cls.is_hlt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2 <= SLOT_NONE;
            s3 <= SLOT_NONE;
            s4 <= SLOT_NONE;
        end else if (active) begin
            s4 <= s3;
            if (flush) begin
                s3 <= SLOT_NONE;
                s2 <= SLOT_NONE;
            end else begin
                s3 <= s2;
                s2 <= issue ? id_tag : SLOT_NONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            retired      <= '0;
        end else if (active) begin
            if (id_stall && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + 1'b1;
            if (s4.valid)
                retired <= retired + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            fetch_en <= 1'b1;
            halted   <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (issue && cls.is_hlt) begin
                        state    <= ST_DRAIN;
                        fetch_en <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // A taken branch that squashes the HLT in EX restarts fetch.
                    if (flush && s2.valid && s2.is_hlt) begin
                        state    <= ST_RUN;
                        fetch_en <= 1'b1;
                    end else if (s4.valid && s4.is_hlt) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: begin
                    state    <= ST_RUN;
                    fetch_en <= 1'b1;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// Directed, table-driven bench for mips_pipe_ctrl plus hand sequences for HLT squash and reset.
module tb_mips_pipe_ctrl;

    localparam logic [5:0] ADD  = 6'b100001;
    localparam logic [5:0] SW   = 6'b000110;
    localparam logic [5:0] ADDI = 6'b001110;
    localparam logic [5:0] HLT  = 6'b111111;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        mem_branch_taken;
    logic        fetch_en, id_stall, id_flush, halted;
    logic [15:0] stall_cycles, retired;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_pipe_ctrl #(.OPW(6), .RW(5), .CNT_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_valid         (id_valid),
        .id_instr         (id_instr),
        .mem_branch_taken (mem_branch_taken),
        .fetch_en         (fetch_en),
        .id_stall         (id_stall),
        .id_flush         (id_flush),
        .halted           (halted),
        .stall_cycles     (stall_cycles),
        .retired          (retired)
    );

    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic        br;
        logic        st;
        logic        fl;
        logic        fe;
        logic        ha;
        int          ret;
        int          stc;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] mk(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, rd[4:0], rs[4:0], rt[4:0], 11'd0};
    endfunction

    task automatic add(input logic v, input logic [31:0] ins, input logic br,
                       input logic st, input logic fl, input logic fe, input logic ha,
                       input int ret, input int stc);
        vec_t x;
        x.v = v; x.ins = ins; x.br = br;
        x.st = st; x.fl = fl; x.fe = fe; x.ha = ha;
        x.ret = ret; x.stc = stc;
        tbl.push_back(x);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic br);
        id_valid = v;
        id_instr = ins;
        mem_branch_taken = br;
        @(negedge clk);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 1'b0;
        id_instr = '0;
        mem_branch_taken = 1'b0;

        //   v  instr               br  st fl fe ha ret stc
        add(1, mk(ADDI, 1, 0, 0),   0,  0, 0, 1, 0, 0,  0);  // c0 independent ops
        add(1, mk(ADDI, 2, 0, 0),   0,  0, 0, 1, 0, 0,  0);
        add(1, mk(ADD,  3, 4, 5),   0,  0, 0, 1, 0, 0,  0);
        add(0, 32'd0,               0,  0, 0, 1, 0, 0,  0);
        add(0, 32'd0,               0,  0, 0, 1, 0, 1,  0);
        add(0, 32'd0,               0,  0, 0, 1, 0, 2,  0);
        add(1, mk(ADDI, 1, 0, 0),   0,  0, 0, 1, 0, 3,  0);  // c6 RAW on rs
        add(1, mk(ADD,  2, 1, 3),   0,  1, 0, 1, 0, 3,  0);
        add(1, mk(ADD,  2, 1, 3),   0,  1, 0, 1, 0, 3,  1);
        add(1, mk(ADD,  2, 1, 3),   0,  1, 0, 1, 0, 3,  2);
        add(1, mk(ADD,  2, 1, 3),   0,  0, 0, 1, 0, 4,  3);
        add(1, mk(ADDI, 6, 0, 0),   0,  0, 0, 1, 0, 4,  3);  // c11 SW rt hazard
        add(1, mk(SW,   0, 0, 6),   0,  1, 0, 1, 0, 4,  3);
        add(1, mk(SW,   0, 0, 6),   0,  1, 0, 1, 0, 4,  4);
        add(1, mk(SW,   0, 0, 6),   0,  1, 0, 1, 0, 5,  5);
        add(1, mk(SW,   0, 0, 6),   0,  0, 0, 1, 0, 6,  6);
        add(1, mk(ADDI, 6, 0, 0),   0,  0, 0, 1, 0, 6,  6);  // c16 SW on r7: no stall
        add(1, mk(SW,   0, 0, 7),   0,  0, 0, 1, 0, 6,  6);
        add(1, mk(ADDI, 9, 0, 0),   0,  0, 0, 1, 0, 6,  6);  // c18 branch squash
        add(1, mk(ADD, 10, 9, 9),   1,  0, 1, 1, 0, 7,  6);
        add(1, mk(ADD, 10, 9, 9),   0,  0, 0, 1, 0, 8,  6);
        add(0, 32'd0,               0,  0, 0, 1, 0, 9,  6);
        add(0, 32'd0,               0,  0, 0, 1, 0, 9,  6);
        add(0, 32'd0,               0,  0, 0, 1, 0, 9,  6);
        add(1, mk(HLT,  0, 0, 0),   0,  0, 0, 1, 0, 10, 6);  // c24 halt
        add(1, mk(ADDI, 1, 0, 0),   0,  0, 0, 0, 0, 10, 6);
        add(1, mk(ADD,  1, 1, 1),   0,  0, 0, 0, 0, 10, 6);
        add(0, 32'd0,               0,  0, 0, 0, 0, 10, 6);
        add(1, mk(ADDI, 1, 0, 0),   1,  0, 0, 0, 1, 11, 6);
        add(1, mk(ADD,  2, 1, 1),   0,  0, 0, 0, 1, 11, 6);
        add(0, 32'd0,               0,  0, 0, 0, 1, 11, 6);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_fetch_en", fetch_en, 1);
        chk("reset_id_stall", id_stall, 0);
        chk("reset_id_flush", id_flush, 0);
        chk("reset_halted", halted, 0);
        chk("reset_stall_cycles", stall_cycles, 0);
        chk("reset_retired", retired, 0);
        tick();

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].ins, tbl[i].br);
            chk($sformatf("c%0d_id_stall", i), id_stall, tbl[i].st);
            chk($sformatf("c%0d_id_flush", i), id_flush, tbl[i].fl);
            chk($sformatf("c%0d_fetch_en", i), fetch_en, tbl[i].fe);
            chk($sformatf("c%0d_halted", i), halted, tbl[i].ha);
            chk($sformatf("c%0d_retired", i), retired, tbl[i].ret);
            chk($sformatf("c%0d_stall_cycles", i), stall_cycles, tbl[i].stc);
            tick();
        end

        // Reset leaves HALTED asynchronously.
        rst = 1'b1;
        #2;
        chk("rst_clears_halted", halted, 0);
        chk("rst_clears_retired", retired, 0);
        rst = 1'b0;
        tick();

        // HLT squashed in EX by a taken branch: back to RUN.
        step(1, mk(HLT, 0, 0, 0), 0);
        chk("hsq_fetch_before", fetch_en, 1);
        tick();
        step(0, 32'd0, 1);
        chk("hsq_flush", id_flush, 1);
        chk("hsq_fetch_drain", fetch_en, 0);
        tick();
        step(0, 32'd0, 0);
        chk("hsq_fetch_resumed", fetch_en, 1);
        tick();
        repeat (4) begin
            step(0, 32'd0, 0);
            tick();
        end
        step(0, 32'd0, 0);
        chk("hsq_not_halted", halted, 0);
        chk("hsq_retired", retired, 0);
        chk("hsq_fetch_later", fetch_en, 1);
        tick();

        // Reset pulse in the middle of DRAIN.
        step(1, mk(ADDI, 1, 0, 0), 0);
        tick();
        repeat (4) begin
            step(1, mk(ADD, 2, 1, 0), 0);
            tick();
        end
        step(1, mk(HLT, 0, 0, 0), 0);
        tick();
        step(0, 32'd0, 0);
        chk("drain_fetch_en", fetch_en, 0);
        chk("drain_stall_cycles", stall_cycles, 3);
        chk("drain_retired", retired, 1);
        rst = 1'b1;
        #1;
        chk("rst_drain_fetch_en", fetch_en, 1);
        chk("rst_drain_stall_cycles", stall_cycles, 0);
        chk("rst_drain_retired", retired, 0);
        chk("rst_drain_halted", halted, 0);
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_pipe_ctrl.md
Name: mips_pipe_ctrl

Overview:
- Central interlock and sequencing controller for the 5-stage MIPS pipeline: IF(0), ID(1), EX(2), MEM(3), WB(4).
- Keeps a shadow pipeline of in-flight instruction tags in EX/MEM/WB and detects RAW hazards against the instruction in ID.
- Drives stall, flush and fetch-enable; runs the HLT drain/halt sequence; keeps stall and retire counters for bring-up.

Parameters:
- OPW, 6, opcode width (instr[31:26])
- RW, 5, register index width
- CNT_W, 16, width of stall/retire counters

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_instr  in  32  instruction in ID; rd=[25:21], rs=[20:16], rt=[15:11]
- mem_branch_taken  in  1  branch in MEM resolved taken this cycle
- fetch_en  out  1  IF may fetch and advance pc0
- id_stall  out  1  hold IF/ID registers and pc0; EX receives a bubble
- id_flush  out  1  squash IF/ID and ID/EX contents (load NO_OP)
- halted  out  1  pipeline halted; sticky until rst
- stall_cycles  out  CNT_W  saturating count of cycles with id_stall=1
- retired  out  CNT_W  wrapping count of non-bubble instructions leaving WB

Behaviour:
- Reset values: fetch_en=1, id_stall=0, id_flush=0, halted=0, counters=0, all shadow slots invalid, FSM=RUN.
- id_stall and id_flush are combinational from current state and ID inputs (same cycle). Everything else is registered.
- Shadow slot s2/s3/s4 = {valid, writes, rd, is_hlt}.
- Decode classes:
  - Writes rd: ADD, SUB, AND, OR, SLT, MUL, LW, ADDI, SUBI, SLTI.
  - Reads rs and rt: ADD, SUB, AND, OR, SLT, MUL, SW.
  - Reads rs only: LW, ADDI, SUBI, SLTI, BEQZ, BNEQZ.
  - NO_OP and HLT read nothing.
- r0 is an ordinary register; no special case.
- hazard = id_valid AND some read source equals rd of any valid, writing slot in s2, s3 or s4.
  - WB is included because the register bank writes at the same edge the ID read occurs.
- Flush, when mem_branch_taken=1:
  - id_flush=1 and id_stall=0 (flush wins over stall).
  - Next edge: s4<=s3, s3<=invalid, s2<=invalid. The squashed EX slot releases its hazard immediately.
- Stall, when not flushing and (hazard or FSM!=RUN with id_valid):
  - id_stall=1 only when hazard.
  - Next edge: s2<=invalid, s3<=s2, s4<=s3.
- Issue, otherwise, when id_valid and FSM=RUN: s2<=ID tag, s3<=s2, s4<=s3.
- stall_cycles increments on each edge with id_stall=1 and saturates at all-ones.
- retired increments when s4.valid; it counts HLT itself.
- FSM states:
  - RUN: fetch_en=1. Issue of HLT -> DRAIN.
  - DRAIN: fetch_en=0; no further issue (ID content ignored).
    - If mem_branch_taken squashes the HLT (HLT in s2) -> RUN, fetch resumes.
    - When s4.is_hlt -> HALTED.
  - HALTED: fetch_en=0, halted=1, shadow frozen, counters frozen, id_stall=0, id_flush=0. Exit only by rst.
- Simultaneous events:
  - Branch taken in the same cycle HLT sits in ID: flush wins, HLT is not issued, FSM stays RUN.
  - Branch taken with HLT already in s3 or s4 is impossible; no action needed.
- rst asserted mid-DRAIN or mid-stall: immediate return to reset values; no partial counter update.

Decomposition:
- Package mips_pkg holds:
  - opcode constants (ADD=100001, SUB=100010, AND=100100, OR=101000, SLT=110000, MUL=100000, HLT=111111, LW=000011, SW=000110, ADDI=001110, SUBI=001101, SLTI=010000, BNEQZ=000111, BEQZ=011110, NO_OP=000000);
  - FSM state encoding {RUN, DRAIN, HALTED};
  - shadow-slot struct/width constants.
- Sub-module mips_opclass: combinational opcode -> {reads_rs, reads_rt, writes_rd, is_hlt}. The datapath reuses it later.

Test Plan:
- Independent ops: ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r4,r5 on consecutive cycles -> id_stall never 1; retired=3 at 3 cycles after last issue; stall_cycles=0.
- RAW: ADDI r1 issued at cycle t, ADD r2,r1,r3 in ID at t+1 -> id_stall=1 at t+1..t+3; issue at t+4; stall_cycles=3.
- SW rt hazard: ADDI r6 then SW r0,r6 -> 3 stall cycles. Same sequence with the SW source on r7 -> 0 stalls.
- Branch squash: ADDI r9 in s2 when mem_branch_taken=1 -> id_flush=1 that cycle. Next cycle an ADD reading r9 in ID issues with no stall; the squashed ADDI is not counted in retired.
- Halt: HLT issued at t -> fetch_en=0 from t+1; halted=1 after HLT reaches s4 (t+3 edge); further id_valid ignored; counters frozen.
- HLT squash and reset: HLT in s2 with mem_branch_taken=1 -> FSM back to RUN, fetch_en=1 next cycle. Separately, rst pulse during DRAIN -> fetch_en=1, counters=0, halted=0 immediately.
